// File: rtl/io_bus_master.sv
// Initiator for the bit-per-address I/O window: one write sweep then one pipelined read sweep per pass.
// Optional IO_AUTO_RESCAN_EN: with auto_en=1, a new pass starts RESCAN_GAP idle cycles after each DONE.
//
//   state | meaning
//   IDLE  | waiting for start
//   WRITE | one cycle per channel, masked write of the latched value bit
//   READ  | one read issued per channel, capture lags issue by one cycle
//   DRAIN | capture last channel, publish rd_shadow
//   DONE  | done pulse
//   GAP   | auto-rescan countdown (IO_AUTO_RESCAN_EN only)
module io_bus_master #(
    parameter int                   WIDTH      = 16,
    parameter int                   ADDR_BITS  = 16,
    parameter logic [ADDR_BITS-1:0] BASE_ADR   = '0,
    parameter int                   N_CH       = 32,
    parameter int                   RESCAN_GAP = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          wr_value,
    input  logic [31:0]          wr_mask,
    input  logic                 auto_en,
    input  logic [WIDTH-1:0]     memdata,
    output logic                 en,
    output logic                 memwrite,
    output logic                 memread,
    output logic [ADDR_BITS-1:0] adr,
    output logic [WIDTH-1:0]     writedata,
    output logic [31:0]          rd_shadow,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
`ifdef IO_AUTO_RESCAN_EN
        , S_GAP
`endif
    } state_t;

    localparam logic [4:0]  LAST    = 5'(N_CH - 1);
    localparam logic [31:0] CH_MASK = 32'((64'd1 << N_CH) - 64'd1);

    state_t                 state_q, state_d;
    logic [4:0]             idx_q, idx_d;
    logic [31:0]            value_q, value_d;
    logic [31:0]            mask_q, mask_d;
    logic [31:0]            work_q, work_d;
    logic [31:0]            rd_shadow_q, rd_shadow_d;
    logic                   en_q, en_d;
    logic                   memwrite_q, memwrite_d;
    logic                   memread_q, memread_d;
    logic [ADDR_BITS-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]       writedata_q, writedata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   launch;

`ifdef IO_AUTO_RESCAN_EN
    logic [15:0]            gap_cnt_q, gap_cnt_d;
`else
    logic                   unused_auto_en;
    assign unused_auto_en = auto_en;
`endif
    logic                   unused_memdata;
    assign unused_memdata = ^memdata[WIDTH-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            work_q      <= '0;
            rd_shadow_q <= '0;
            en_q        <= 1'b0;
            memwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            adr_q       <= '0;
            writedata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef IO_AUTO_RESCAN_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            mask_q      <= mask_d;
            work_q      <= work_d;
            rd_shadow_q <= rd_shadow_d;
            en_q        <= en_d;
            memwrite_q  <= memwrite_d;
            memread_q   <= memread_d;
            adr_q       <= adr_d;
            writedata_q <= writedata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef IO_AUTO_RESCAN_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        value_d     = value_q;
        mask_d      = mask_q;
        work_d      = work_q;
        rd_shadow_d = rd_shadow_q;
        launch      = 1'b0;
`ifdef IO_AUTO_RESCAN_EN
        gap_cnt_d   = gap_cnt_q;
`endif

        case (state_q)
            S_IDLE: launch = start;
            S_WRITE: begin
                if (idx_q == LAST) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_READ: begin
                if (idx_q != 5'd0)
                    work_d[idx_q - 5'd1] = memdata[0];
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_DRAIN: begin
                work_d[LAST] = memdata[0];
                rd_shadow_d  = work_d & CH_MASK;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef IO_AUTO_RESCAN_EN
                if (auto_en) begin
                    if (RESCAN_GAP == 0) begin
                        launch = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = 16'(RESCAN_GAP - 1);
                    end
                end
`endif
            end
`ifdef IO_AUTO_RESCAN_EN
            S_GAP: begin
                if (!auto_en)
                    state_d = S_IDLE;
                else if (start || gap_cnt_q == 16'd0)
                    launch = 1'b1;
                else
                    gap_cnt_d = gap_cnt_q - 16'd1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d = S_WRITE;
            idx_d   = '0;
            value_d = wr_value;
            mask_d  = wr_mask;
        end

        // Bus outputs are registered from the next state so each channel appears in its own cycle.
        en_d        = 1'b0;
        memwrite_d  = 1'b0;
        memread_d   = 1'b0;
        adr_d       = '0;
        writedata_d = '0;
        if (state_d == S_WRITE && mask_d[idx_d]) begin
            en_d        = 1'b1;
            memwrite_d  = 1'b1;
            adr_d       = BASE_ADR | ADDR_BITS'(idx_d);
            writedata_d = WIDTH'(value_d[idx_d]);
        end else if (state_d == S_READ) begin
            en_d      = 1'b1;
            memread_d = 1'b1;
            adr_d     = BASE_ADR | ADDR_BITS'(idx_d);
        end
        busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    assign en        = en_q;
    assign memwrite  = memwrite_q;
    assign memread   = memread_q;
    assign adr       = adr_q;
    assign writedata = writedata_q;
    assign rd_shadow = rd_shadow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a bit-per-address I/O window model (default build).
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] wr_value;
    logic [31:0] wr_mask;
    logic        auto_en;
    logic [15:0] memdata;
    logic        en, memwrite, memread, busy, done;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic [31:0] rd_shadow;

    logic [31:0] in_dev;
    logic [31:0] out_dev;
    logic        win_clr;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    io_bus_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .wr_value  (wr_value),
        .wr_mask   (wr_mask),
        .auto_en   (auto_en),
        .memdata   (memdata),
        .en        (en),
        .memwrite  (memwrite),
        .memread   (memread),
        .adr       (adr),
        .writedata (writedata),
        .rd_shadow (rd_shadow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (win_clr)
            out_dev <= '0;
        else if (en && memwrite)
            out_dev[adr[4:0]] <= writedata[0];
        if (en && memread)
            memdata <= {15'b0, in_dev[adr[4:0]]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bus_obs();
        return {27'b0, en, memwrite, memread, busy, done, adr, writedata};
    endfunction

    // Expected {en,memwrite,memread,busy,done,adr,writedata} in cycle k after E0.
    function automatic logic [63:0] exp_bus(input int k, input logic [31:0] v, input logic [31:0] m);
        logic e, mw, mr, b, d;
        logic [15:0] a, wd;
        e = 0; mw = 0; mr = 0; b = 0; d = 0; a = '0; wd = '0;
        if (k < 32) begin
            b = 1;
            if (m[k]) begin
                e = 1; mw = 1; a = 16'(k); wd = {15'b0, v[k]};
            end
        end else if (k < 64) begin
            b = 1; e = 1; mr = 1; a = 16'(k - 32);
        end else if (k == 64) begin
            b = 1;
        end else if (k == 65) begin
            d = 1;
        end
        return {27'b0, e, mw, mr, b, d, a, wd};
    endfunction

    task automatic run_pass(input logic [31:0] value, input logic [31:0] mask,
                            input logic [31:0] in0, input logic [31:0] exp_sh,
                            input int restart_at, input int change_at,
                            input logic [31:0] in1, input int ncyc);
        int dones;
        dones    = 0;
        wr_value = value;
        wr_mask  = mask;
        in_dev   = in0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            chk($sformatf("bus k=%0d", k), bus_obs(), exp_bus(k, value, mask));
            if (done) dones++;
            if (k == 65) chk("rd_shadow", {32'b0, rd_shadow}, {32'b0, exp_sh});
            if (k == restart_at) begin
                start    = 1'b1;
                wr_value = ~value;
                wr_mask  = ~mask;
            end else begin
                start = 1'b0;
            end
            if (k == change_at) in_dev = in1;
            tick();
        end
        start = 1'b0;
        chk("done_pulses", 64'(dones), 64'd1);
    endtask

    initial begin
        int seen;
        reset    = 1'b1;
        start    = 1'b0;
        wr_value = '0;
        wr_mask  = '0;
        auto_en  = 1'b0;
        in_dev   = '0;
        win_clr  = 1'b1;
        #3;
        chk("reset_bus", bus_obs(), 64'd0);
        chk("reset_shadow", {32'b0, rd_shadow}, 64'd0);
        #10;
        reset = 1'b0;
        tick();
        win_clr = 1'b0;
        tick();

        // full write + read of 8000_0001
        run_pass(32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, -1, -1, 32'h0, 70);
        chk("out_full", {32'b0, out_dev}, {32'b0, 32'hA5A5_0F0F});

        // reset mid-write at channel 5
        wr_value = 32'hFFFF_FFFF;
        wr_mask  = 32'hFFFF_FFFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_ch5", bus_obs(), exp_bus(5, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_bus", {61'b0, en, memwrite, busy}, 64'd0);
        chk("async_reset_shadow", {32'b0, rd_shadow}, 64'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("idle_after_reset", bus_obs(), 64'd0);

        // masked write after reset, full pass
        win_clr = 1'b1;
        tick();
        win_clr = 1'b0;
        run_pass(32'hFFFF_FFFF, 32'h0000_00F0, 32'h5555_AAAA, 32'h5555_AAAA, -1, -1, 32'h0, 68);
        chk("out_masked", {32'b0, out_dev}, {32'b0, 32'h0000_00F0});

        // start while busy, input change mid-read, mask/value changes ignored, auto_en ignored
        win_clr = 1'b1;
        tick();
        win_clr = 1'b0;
        auto_en = 1'b1;
        run_pass(32'h0, 32'h0, 32'h0, 32'h1234_5600, 10, 40, 32'h1234_5678, 85);
        chk("out_untouched", {32'b0, out_dev}, 64'd0);
        auto_en = 1'b0;

        // start held high re-triggers on return to IDLE
        wr_value = 32'h1;
        wr_mask  = 32'h1;
        in_dev   = 32'h0;
        start    = 1'b1;
        tick();
        repeat (65) tick();
        chk("held_done", {63'b0, done}, 64'd1);
        tick();
        chk("held_idle", bus_obs(), 64'd0);
        tick();
        chk("held_retrigger", bus_obs(), exp_bus(0, 32'h1, 32'h1));
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 80 && seen == 0; i++) begin
            if (done) seen = 1;
            else tick();
        end
        chk("retrigger_done_seen", 64'(seen), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
